fir_parallel_reload: RTL and testbench
======================================

# fir_parallel_reload

Parametrised parallel-sample FIR for the PUEO SURF trigger path, successor to the fixed-coefficient low-pass/matched-filter chain. Processes NSAMP ADC samples per clock, with NTAPS runtime-reloadable coefficients behind a double-buffered bank. Each output is the causal convolution across lane and clock boundaries, rounded and optionally saturated. Sits between the ADC sample unpacker and the beamformer/threshold logic.

## Interface
- NSAMP, 8, samples per clock (lane 0 oldest, lane NSAMP-1 newest)
- INBITS, 12, signed input sample width
- NTAPS, 8, FIR taps; 1 ≤ NTAPS ≤ NSAMP+1
- COEFBITS, 16, signed coefficient width
- COEF_FRAC, 14, coefficient fractional bits; must be ≥1
- OUTBITS, 13, signed output sample width
- clk_i  in  1  sample clock
- rstn_i  in  1  asynchronous, active-low reset
- dat_i  in  NSAMP*INBITS  packed input lanes
- dat_o  out  NSAMP*OUTBITS  packed filtered lanes
- coef_i  in  COEFBITS  coefficient beat, tap 0 first
- coef_valid_i  in  1  beat valid
- coef_last_i  in  1  marks final beat of a load
- coef_ready_o  out  1  block accepts a beat
- coef_err_o  out  1  sticky: malformed load detected
- coef_err_clr_i  in  1  clears coef_err_o

## Operation
- y[n] = Σ_{k=0}^{NTAPS-1} c[k]·x[n−k]; x[n−k] for k > lane index comes from the previous clock's lanes (a one-word history register).
- Full-precision sum width: INBITS+COEFBITS+clog2(NTAPS). Round: add 2^(COEF_FRAC−1), then arithmetic shift right by COEF_FRAC. Narrow to OUTBITS per Configuration.
- Active bank reset value: c[0] = 2^COEF_FRAC, all others 0, so dat_o equals dat_i delayed (identity).
- Load FSM states: IDLE, LOAD, COMMIT.
  - IDLE: coef_ready_o=1. An accepted beat writes shadow[0] and moves to LOAD with count=1. If it also has last: with NTAPS=1 go to COMMIT, otherwise it is an error.
  - LOAD: each accepted beat writes shadow[count] and increments count. When last arrives with count==NTAPS−1, go to COMMIT. When last arrives early, or a beat arrives at count==NTAPS without last: set coef_err_o, discard the shadow bank, return to IDLE.
  - COMMIT: coef_ready_o=0 for exactly one cycle; shadow is copied to active; return to IDLE.
- Accept = coef_valid_i & coef_ready_o on a rising edge.
- coef_err_clr_i clears the error on the next edge. If a new error occurs on the same edge, set wins.

## Timing
- Latency is 3 clocks from dat_i to dat_o: input/history register, then product register, then adder tree + round/saturate register.
- The data path is free-running: there is no valid qualifier, and a new word is taken every clock.
- Bank swap: if the COMMIT state is occupied during cycle C, the active bank changes at the end of C. Input words sampled at the end of C or later use the new coefficients. The bank select is pipelined with the data, so no output word ever mixes coefficients from two banks.
- History spanning the swap uses old samples with the new coefficients. This is intended.
- Reset (asynchronous assert, synchronous release):
  - dat_o=0, pipeline and history=0.
  - FSM=IDLE, coef_ready_o=1 after release, coef_err_o=0.
  - Active bank returns to identity and the shadow is cleared.
  - Reset during LOAD abandons the load; the active bank is not modified by partial loads.

## Configuration
- FIR_SATURATE_EN defined: the rounded sum is clamped to [−2^(OUTBITS−1), 2^(OUTBITS−1)−1].
- FIR_SATURATE_EN undefined: the rounded sum is truncated to its low OUTBITS bits (two's-complement wrap). This saves the comparator logic.

## Test plan
- After reset, drive lane 6 = 1000 for one clock. Required: dat_o lane 6 = 1000 exactly 3 clocks later; all other lanes 0.
- Load c = {8192, 16384, 8192, 0, 0, 0, 0, 0} (last on beat 8), then impulse lane 6 = 1000. Required: lane 6 = 500, lane 7 = 1000, next clock lane 0 = 500; coef_ready_o low for one cycle after beat 8.
- Load with coef_last_i on beat 5. Required: coef_err_o = 1, active bank unchanged (impulse still passes through as identity). coef_err_clr_i pulse then clears it.
- Load c = {16384, 16384, 16384, 0, …} with all lanes held at 2047. Required: steady-state output 4095 with FIR_SATURATE_EN, −2051 without.
- Assert rstn_i mid-load after beat 4, release, then send an impulse. Required: identity response and coef_err_o = 0.
- Stream a constant input while committing a new bank. Required: each output word equals the all-old-coefficient or all-new-coefficient value, never a mix.

Source files
------------

// File: rtl/fir_parallel_reload.sv
// fir_parallel_reload: NSAMP-lane causal FIR with a double-buffered, runtime-reloadable coefficient bank.
// Define FIR_SATURATE_EN to clamp the rounded output; otherwise it wraps to OUTBITS.
module fir_parallel_reload #(
    parameter int NSAMP     = 8,
    parameter int INBITS    = 12,
    parameter int NTAPS     = 8,
    parameter int COEFBITS  = 16,
    parameter int COEF_FRAC = 14,
    parameter int OUTBITS   = 13
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NSAMP*INBITS-1:0]    dat_i,
    output logic [NSAMP*OUTBITS-1:0]   dat_o,
    input  logic [COEFBITS-1:0]        coef_i,
    input  logic                       coef_valid_i,
    input  logic                       coef_last_i,
    output logic                       coef_ready_o,
    output logic                       coef_err_o,
    input  logic                       coef_err_clr_i
);
    localparam int PW = INBITS + COEFBITS;
    localparam int SW = PW + $clog2(NTAPS);
    localparam int CW = $clog2(NTAPS + 1);
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [SW-1:0] OMAX = (SW'(1) <<< (OUTBITS - 1)) - SW'(1);
    localparam logic signed [SW-1:0] OMIN = -OMAX - SW'(1);
    localparam logic signed [COEFBITS-1:0] ONE = COEFBITS'(1) <<< COEF_FRAC;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic signed [COEFBITS-1:0] shadow [NTAPS];
    logic signed [COEFBITS-1:0] active [NTAPS];
    logic acc, wr, err_set, discard, commit;

    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q;
        wr           = 1'b0;
        err_set      = 1'b0;
        discard      = 1'b0;
        commit       = 1'b0;
        coef_ready_o = st_q != COMMIT;
        acc          = coef_valid_i & coef_ready_o;
        case (st_q)
            IDLE: if (acc) begin
                wr      = 1'b1;
                err_set = coef_last_i && NTAPS != 1;
                discard = err_set;
                cnt_d   = coef_last_i ? '0 : CW'(1);
                st_d    = !coef_last_i ? LOAD : (NTAPS == 1 ? COMMIT : IDLE);
            end
            LOAD: if (acc) begin
                // a terminating beat is only legal at the last tap; anything else aborts the load
                err_set = coef_last_i ? cnt_q != CW'(NTAPS - 1) : cnt_q == CW'(NTAPS);
                discard = err_set;
                wr      = !err_set;
                cnt_d   = (err_set || coef_last_i) ? '0 : cnt_q + CW'(1);
                st_d    = err_set ? IDLE : (coef_last_i ? COMMIT : LOAD);
            end
            default: begin
                commit = 1'b1;
                st_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            st_q       <= IDLE;
            cnt_q      <= '0;
            coef_err_o <= 1'b0;
            for (int t = 0; t < NTAPS; t++) begin
                shadow[t] <= '0;
                active[t] <= (t == 0) ? ONE : '0;
            end
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            coef_err_o <= err_set | (coef_err_o & ~coef_err_clr_i);
            for (int t = 0; t < NTAPS; t++) begin
                if (discard)
                    shadow[t] <= '0;
                else if (wr && cnt_q == CW'(t))
                    shadow[t] <= coef_i;
                if (commit)
                    active[t] <= shadow[t];
            end
        end
    end

    logic [NSAMP*INBITS-1:0] x_q, h_q;
    logic signed [INBITS-1:0] smp [NSAMP][NTAPS];
    logic signed [PW-1:0] prod_q [NSAMP][NTAPS];
    logic signed [SW-1:0] sum, r;
    logic [NSAMP*OUTBITS-1:0] y;

    for (genvar i = 0; i < NSAMP; i++) begin : g_lane
        for (genvar k = 0; k < NTAPS; k++) begin : g_tap
            if (k <= i) begin : g_cur
                assign smp[i][k] = $signed(x_q[(i-k)*INBITS +: INBITS]);
            end else begin : g_hist
                assign smp[i][k] = $signed(h_q[(NSAMP+i-k)*INBITS +: INBITS]);
            end
        end
    end

    always_comb begin
        y   = '0;
        sum = '0;
        r   = '0;
        for (int i = 0; i < NSAMP; i++) begin
            sum = '0;
            for (int k = 0; k < NTAPS; k++)
                sum = sum + SW'(prod_q[i][k]);
            r = (sum + RND) >>> COEF_FRAC;
`ifdef FIR_SATURATE_EN
            y[i*OUTBITS +: OUTBITS] = r > OMAX ? OUTBITS'(OMAX) : r < OMIN ? OUTBITS'(OMIN) : OUTBITS'(r);
`else
            y[i*OUTBITS +: OUTBITS] = OUTBITS'(r);
`endif
        end
    end

    // products are formed with the bank live while the word sits in x_q, so a swap never splits a word
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_q   <= '0;
            h_q   <= '0;
            dat_o <= '0;
            for (int i = 0; i < NSAMP; i++)
                for (int k = 0; k < NTAPS; k++)
                    prod_q[i][k] <= '0;
        end else begin
            x_q   <= dat_i;
            h_q   <= x_q;
            dat_o <= y;
            for (int i = 0; i < NSAMP; i++)
                for (int k = 0; k < NTAPS; k++)
                    prod_q[i][k] <= smp[i][k] * active[k];
        end
    end
endmodule

// File: tb/tb_fir_parallel_reload.sv
// tb_fir_parallel_reload: directed checks of fir_parallel_reload filtering, coefficient loading and error handling.
module tb_fir_parallel_reload;
    localparam int NS = 8, IB = 12, NT = 8, CB = 16, CF = 14, OB = 13;
`ifdef FIR_SATURATE_EN
    localparam int SATV = 4095;
`else
    localparam int SATV = -2051;
`endif

    logic clk = 1'b0;
    logic rstn_i;
    logic [NS*IB-1:0] dat_i;
    logic [NS*OB-1:0] dat_o;
    logic [CB-1:0] coef_i;
    logic coef_valid_i, coef_last_i, coef_ready_o, coef_err_o, coef_err_clr_i;

    int checks = 0;
    int errors = 0;
    logic signed [CB-1:0] coefs [NT];
    logic [NS*OB-1:0] exp_o;

    always #5 clk = ~clk;

    fir_parallel_reload #(
        .NSAMP(NS), .INBITS(IB), .NTAPS(NT), .COEFBITS(CB), .COEF_FRAC(CF), .OUTBITS(OB)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn_i), .dat_i(dat_i), .dat_o(dat_o),
        .coef_i(coef_i), .coef_valid_i(coef_valid_i), .coef_last_i(coef_last_i),
        .coef_ready_o(coef_ready_o), .coef_err_o(coef_err_o), .coef_err_clr_i(coef_err_clr_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NS*IB-1:0] in_all(input int v);
        logic [NS*IB-1:0] w;
        for (int l = 0; l < NS; l++) w[l*IB +: IB] = IB'(v);
        return w;
    endfunction

    function automatic logic [NS*OB-1:0] out_all(input int v);
        logic [NS*OB-1:0] w;
        for (int l = 0; l < NS; l++) w[l*OB +: OB] = OB'(v);
        return w;
    endfunction

    task automatic load(input int nb, input int last_at);
        for (int b = 0; b < nb; b++) begin
            coef_i       = coefs[b % NT];
            coef_valid_i = 1'b1;
            coef_last_i  = (b + 1 == last_at);
            step();
        end
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; dat_i = in_all(77); coef_i = '0;
        coef_valid_i = 1'b0; coef_last_i = 1'b0; coef_err_clr_i = 1'b0;
        repeat (3) step();
        rstn_i = 1'b1;
        dat_i  = '0;
        step();
        checks++; if (dat_o !== '0) begin errors++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
        checks++; if (coef_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", coef_ready_o); end
        checks++; if (coef_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", coef_err_o); end
        repeat (3) step();
    endtask

    task automatic test_identity();
        dat_i = '0; dat_i[6*IB +: IB] = IB'(1000);
        step();
        dat_i = '0;
        step();
        checks++; if (dat_o !== '0) begin errors++; $display("FAIL ident_early: got %h expected 0", dat_o); end
        step();
        exp_o = '0; exp_o[6*OB +: OB] = OB'(1000);
        checks++; if (dat_o !== exp_o) begin errors++; $display("FAIL ident_lat3: got %h expected %h", dat_o, exp_o); end
        step();
        checks++; if (dat_o !== '0) begin errors++; $display("FAIL ident_after: got %h expected 0", dat_o); end
    endtask

    task automatic test_load_error();
        for (int t = 0; t < NT; t++) coefs[t] = 16'sd4096;
        load(5, 5);
        checks++; if (coef_err_o !== 1'b1) begin errors++; $display("FAIL err_early_last: got %b expected 1", coef_err_o); end
        checks++; if (coef_ready_o !== 1'b1) begin errors++; $display("FAIL err_ready: got %b expected 1", coef_ready_o); end
        step();
        dat_i = '0; dat_i[3*IB +: IB] = IB'(-700);
        step();
        dat_i = '0;
        repeat (2) step();
        exp_o = '0; exp_o[3*OB +: OB] = OB'(-700);
        checks++; if (dat_o !== exp_o) begin errors++; $display("FAIL err_bank_kept: got %h expected %h", dat_o, exp_o); end
        coef_err_clr_i = 1'b1;
        step();
        coef_err_clr_i = 1'b0;
        checks++; if (coef_err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", coef_err_o); end
        load(9, 0);
        checks++; if (coef_err_o !== 1'b1) begin errors++; $display("FAIL err_overrun: got %b expected 1", coef_err_o); end
        coef_err_clr_i = 1'b1;
        step();
        coef_err_clr_i = 1'b0;
        checks++; if (coef_err_o !== 1'b0) begin errors++; $display("FAIL err_clear2: got %b expected 0", coef_err_o); end
    endtask

    task automatic test_load();
        coefs = '{16'sd8192, 16'sd16384, 16'sd8192, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        load(8, 8);
        checks++; if (coef_ready_o !== 1'b0) begin errors++; $display("FAIL commit_ready_low: got %b expected 0", coef_ready_o); end
        step();
        checks++; if (coef_ready_o !== 1'b1) begin errors++; $display("FAIL commit_ready_back: got %b expected 1", coef_ready_o); end
        checks++; if (coef_err_o !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", coef_err_o); end
        repeat (3) step();
        dat_i = '0; dat_i[6*IB +: IB] = IB'(1000);
        step();
        dat_i = '0;
        repeat (2) step();
        exp_o = '0; exp_o[6*OB +: OB] = OB'(500); exp_o[7*OB +: OB] = OB'(1000);
        checks++; if (dat_o !== exp_o) begin errors++; $display("FAIL lp_word0: got %h expected %h", dat_o, exp_o); end
        step();
        exp_o = '0; exp_o[0 +: OB] = OB'(500);
        checks++; if (dat_o !== exp_o) begin errors++; $display("FAIL lp_word1: got %h expected %h", dat_o, exp_o); end
    endtask

    task automatic test_saturate();
        coefs = '{16'sd16384, 16'sd16384, 16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        load(8, 8);
        step();
        dat_i = in_all(2047);
        repeat (5) step();
        checks++; if (dat_o !== out_all(SATV)) begin errors++; $display("FAIL sat_steady: got %h expected %h", dat_o, out_all(SATV)); end
        dat_i = '0;
        repeat (4) step();
        checks++; if (dat_o !== '0) begin errors++; $display("FAIL sat_drain: got %h expected 0", dat_o); end
    endtask

    task automatic test_midload_reset();
        for (int t = 0; t < NT; t++) coefs[t] = 16'sd0;
        load(4, 0);
        rstn_i = 1'b0;
        #1;
        checks++; if (dat_o !== '0) begin errors++; $display("FAIL async_reset_dat: got %h expected 0", dat_o); end
        step();
        rstn_i = 1'b1;
        step();
        checks++; if (coef_err_o !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", coef_err_o); end
        checks++; if (coef_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", coef_ready_o); end
        dat_i = '0; dat_i[1*IB +: IB] = IB'(333);
        step();
        dat_i = '0;
        repeat (2) step();
        exp_o = '0; exp_o[1*OB +: OB] = OB'(333);
        checks++; if (dat_o !== exp_o) begin errors++; $display("FAIL midreset_ident: got %h expected %h", dat_o, exp_o); end
    endtask

    task automatic test_swap();
        int seen_old, seen_new;
        seen_old = 0;
        seen_new = 0;
        coefs = '{16'sd8192, 16'sd4096, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        dat_i = in_all(100);
        repeat (5) step();
        for (int c = 0; c < 20; c++) begin
            automatic int v0 = $signed(dat_o[0 +: OB]);
            automatic bit uniform = 1'b1;
            for (int l = 1; l < NS; l++)
                if ($signed(dat_o[l*OB +: OB]) != v0) uniform = 1'b0;
            checks++;
            if (!uniform || (v0 != 100 && v0 != 75)) begin
                errors++;
                $display("FAIL swap_word%0d: got %h expected all 100 or all 75", c, dat_o);
            end
            if (v0 == 100) seen_old++;
            if (v0 == 75) seen_new++;
            coef_valid_i = c < NT;
            coef_last_i  = c == NT - 1;
            coef_i       = coefs[c % NT];
            step();
        end
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
        checks++; if (dat_o !== out_all(75)) begin errors++; $display("FAIL swap_final: got %h expected %h", dat_o, out_all(75)); end
        checks++; if (seen_old == 0 || seen_new == 0) begin errors++; $display("FAIL swap_both_banks: got old=%0d new=%0d expected both nonzero", seen_old, seen_new); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_load_error();
        test_load();
        test_saturate();
        test_midload_reset();
        test_swap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
